// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and counter sizing helper.
package alu_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Width of an iteration counter that must hold values up to n-1.
    function automatic int unsigned count_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_nb.sv
// Combinational ripple subtractor: diff = a + ~b + cin, no_borrow is the carry out.
module sub_nb #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign diff[i]      = a[i] ^ ~b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & ~b[i]) | (a[i] & carry[i]) | (~b[i] & carry[i]);
    end

    assign no_borrow = carry[W];

endmodule

// File: rtl/div_restoring.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/done handshake.
module div_restoring
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned RW = N + 1;
    localparam int unsigned CW = count_width(N);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [RW-1:0] r;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;

    logic [RW-1:0] rs;
    logic [RW-1:0] t;
    logic          no_borrow;
    logic [RW-1:0] r_step;
    logic [N-1:0]  q_step;
    logic          accept;
    logic          iterate;
    logic          div_zero_in;

    // Shift next dividend bit into the partial remainder, then trial-subtract the divisor.
    assign rs = (r << 1) | RW'(q[N-1]);

    sub_nb #(.W(RW)) u_sub (
        .a         (rs),
        .b         ({1'b0, d}),
        .cin       (1'b1),
        .diff      (t),
        .no_borrow (no_borrow)
    );

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath control and single-iteration results.
    always_comb begin
        accept      = 1'b0;
        iterate     = 1'b0;
        div_zero_in = (divisor == '0);
        r_step      = rs;
        q_step      = {q[N-2:0], 1'b0};
        if ((state == S_IDLE) || (state == S_DONE)) begin
            accept = start;
        end
        if (state == S_RUN) begin
            iterate = 1'b1;
        end
        if (no_borrow) begin
            r_step = t;
            q_step = {q[N-2:0], 1'b1};
        end
    end

    // Working and result registers; results only move at completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (div_zero_in) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                r           <= '0;
                q           <= dividend;
                d           <= divisor;
                cnt         <= CW'(N - 1);
                div_by_zero <= 1'b0;
            end
        end else if (iterate) begin
            r <= r_step;
            q <= q_step;
            if (cnt == '0) begin
                quotient  <= q_step;
                remainder <= r_step[N-1:0];
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_div_restoring.sv
// Self-checking bench for div_restoring: directed table, handshake corner cases, random sweeps at N=8 and N=5.
module tb_div_restoring;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend, divisor;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    logic       start5;
    logic [4:0] dividend5, divisor5;
    logic       busy5, done5, div_by_zero5;
    logic [4:0] quotient5, remainder5;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    div_restoring #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    div_restoring #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .dividend(dividend5), .divisor(divisor5),
        .busy(busy5), .done(done5), .quotient(quotient5), .remainder(remainder5),
        .div_by_zero(div_by_zero5)
    );

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
        int lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: plain integer division, divide-by-zero gives all-ones quotient and dividend as remainder.
    task automatic ref_div(input int a, input int b, input int n,
                           output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << n) - 1; r = a; z = 1;
        end else begin
            q = a / b; r = a % b; z = 0;
        end
    endtask

    // Called at a negedge: present a start for one edge, return at the negedge after the accepting edge.
    task automatic issue(input int a, input int b);
        start = 1'b1; dividend = 8'(a); divisor = 8'(b);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns edges from the current sample until done, and how many samples had busy high.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = -1; busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin lat = i; return; end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done5(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (done5) begin lat = i; return; end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[8];
        int lat, bc, eq, er, ez, dcount, a, b;

        vt[0] = '{100, 7, 14, 2, 0, 8};
        vt[1] = '{5, 9, 0, 5, 0, 8};
        vt[2] = '{255, 1, 255, 0, 0, 8};
        vt[3] = '{255, 255, 1, 0, 0, 8};
        vt[4] = '{0, 3, 0, 0, 0, 8};
        vt[5] = '{128, 16, 8, 0, 0, 8};
        vt[6] = '{37, 0, 255, 37, 1, 0};
        vt[7] = '{1, 255, 0, 1, 0, 8};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        start5 = 1'b0; dividend5 = '0; divisor5 = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            issue(vt[i].a, vt[i].b);
            wait_done(lat, bc);
            chk($sformatf("tbl%0d_quotient", i), int'(quotient), vt[i].q);
            chk($sformatf("tbl%0d_remainder", i), int'(remainder), vt[i].r);
            chk($sformatf("tbl%0d_dbz", i), int'(div_by_zero), vt[i].z);
            chk($sformatf("tbl%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("tbl%0d_busy_cycles", i), bc, vt[i].lat);
            @(negedge clk);
            chk($sformatf("tbl%0d_done_pulse", i), int'(done), 0);
        end

        // Start held high with operands changed mid-operation
        start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        @(negedge clk);
        repeat (3) @(negedge clk);
        dividend = 8'd10; divisor = 8'd1;
        wait_done(lat, bc);
        chk("hold_quotient", int'(quotient), 66);
        chk("hold_remainder", int'(remainder), 2);
        chk("hold_latency", lat, 5);
        @(negedge clk);
        chk("hold_restart_busy", int'(busy), 1);
        start = 1'b0;
        wait_done(lat, bc);
        chk("hold_second_quotient", int'(quotient), 10);
        chk("hold_second_remainder", int'(remainder), 0);
        chk("hold_second_latency", lat, 8);
        @(negedge clk);

        // Back-to-back: second start in the done cycle of the first
        issue(100, 7);
        wait_done(lat, bc);
        chk("b2b_first_quotient", int'(quotient), 14);
        start = 1'b1; dividend = 8'd50; divisor = 8'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_held_quotient", int'(quotient), 14);
        chk("b2b_held_remainder", int'(remainder), 2);
        wait_done(lat, bc);
        chk("b2b_second_quotient", int'(quotient), 8);
        chk("b2b_second_remainder", int'(remainder), 2);
        chk("b2b_second_latency", lat + 4, 8);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation
        issue(100, 7);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_quotient", int'(quotient), 0);
        chk("mid_rst_remainder", int'(remainder), 0);
        chk("mid_rst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", dcount, 0);
        issue(9, 2);
        wait_done(lat, bc);
        chk("post_rst_quotient", int'(quotient), 4);
        chk("post_rst_remainder", int'(remainder), 1);
        chk("post_rst_latency", lat, 8);
        @(negedge clk);

        // Random sweep, N=8
        for (int i = 0; i < 150; i++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            ref_div(a, b, 8, eq, er, ez);
            issue(a, b);
            wait_done(lat, bc);
            chk($sformatf("rnd8_%0d/%0d_quotient", a, b), int'(quotient), eq);
            chk($sformatf("rnd8_%0d/%0d_remainder", a, b), int'(remainder), er);
            chk($sformatf("rnd8_%0d/%0d_dbz", a, b), int'(div_by_zero), ez);
            chk($sformatf("rnd8_%0d/%0d_latency", a, b), lat, (b == 0) ? 0 : 8);
            if (b != 0) begin
                chk($sformatf("rnd8_%0d/%0d_identity", a, b), int'(quotient) * b + int'(remainder), a);
                chk($sformatf("rnd8_%0d/%0d_rem_lt_div", a, b), int'(int'(remainder) < b), 1);
            end
            @(negedge clk);
        end

        // Random sweep, N=5
        for (int i = 0; i < 100; i++) begin
            a = int'($urandom_range(0, 31));
            b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
            ref_div(a, b, 5, eq, er, ez);
            start5 = 1'b1; dividend5 = 5'(a); divisor5 = 5'(b);
            @(negedge clk);
            start5 = 1'b0;
            wait_done5(lat);
            chk($sformatf("rnd5_%0d/%0d_quotient", a, b), int'(quotient5), eq);
            chk($sformatf("rnd5_%0d/%0d_remainder", a, b), int'(remainder5), er);
            chk($sformatf("rnd5_%0d/%0d_dbz", a, b), int'(div_by_zero5), ez);
            chk($sformatf("rnd5_%0d/%0d_latency", a, b), lat, (b == 0) ? 0 : 5);
            if (b != 0) begin
                chk($sformatf("rnd5_%0d/%0d_identity", a, b), int'(quotient5) * b + int'(remainder5), a);
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
